// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy state encoding
// and the default bubble control pattern, also consumed by the hazard unit.
package pipe_stage_elastic_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam logic [15:0] DEFAULT_BUBBLE_CTRL = 16'h0000;

  function automatic logic is_occupied(input pipe_state_e s);
    return (s != ST_EMPTY);
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_slot.sv
// One storage slot of the elastic stage: a load-enabled register with an
// asynchronous reset to a caller-chosen value.
module pipe_slot #(
  parameter int unsigned      W       = 48,
  parameter logic [W-1:0]     RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] slot_q;
  logic [W-1:0] slot_d;

  always_comb begin
    slot_d = slot_q;
    if (load_en) slot_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_q <= RST_VAL;
    else     slot_q <= slot_d;
  end

  assign q = slot_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage with a main slot driving the outputs and a skid slot
// that absorbs the one entry accepted while downstream stalls.
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]    BUBBLE_CTRL = CTRL_W'(DEFAULT_BUBBLE_CTRL),
  parameter int unsigned          CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [1:0]        dbg_state
);

  localparam int unsigned SW = DATA_W + CTRL_W;
  localparam logic [SW-1:0] SLOT_RST = {{DATA_W{1'b0}}, BUBBLE_CTRL};

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and in_ready depends only on the
  // registered full flag and flush, so no combinational path runs in -> out.

  pipe_state_e        state_q, state_d;
  logic               in_rdy_q, in_rdy_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic               main_ld, skid_ld;
  logic [SW-1:0]      main_d, main_q, skid_q;
  logic               in_fire, out_fire;

  assign in_ready  = in_rdy_q & ~flush;
  assign out_valid = is_occupied(state_q);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    main_ld     = 1'b0;
    skid_ld     = 1'b0;
    main_d      = main_q;
    if (flush) begin
      // Squash to bubble but keep the last payload on out_data.
      state_d = ST_EMPTY;
      main_ld = 1'b1;
      main_d  = {main_q[SW-1:CTRL_W], BUBBLE_CTRL};
      if (is_occupied(state_q) && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_d = flush_cnt_q + 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_ld = 1'b1;
            main_d  = {in_data, in_ctrl};
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
            main_d  = {in_data, in_ctrl};
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_ld = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_ld = 1'b1;
            main_d  = {main_q[SW-1:CTRL_W], BUBBLE_CTRL};
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_ld = 1'b1;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_rdy_d = (state_d != ST_FULL);
  end

  // in_rdy_q resets low so in_ready rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_rdy_q    <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_rdy_q    <= in_rdy_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  pipe_slot #(.W(SW), .RST_VAL(SLOT_RST)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_en (main_ld),
    .d       (main_d),
    .q       (main_q)
  );

  pipe_slot #(.W(SW), .RST_VAL(SLOT_RST)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_en (skid_ld),
    .d       ({in_data, in_ctrl}),
    .q       (skid_q)
  );

  assign out_data  = main_q[SW-1:CTRL_W];
  assign out_ctrl  = main_q[CTRL_W-1:0];
  assign flush_cnt = flush_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the stage.
module tb_pipe_stage_elastic;

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 16;
  localparam int unsigned CNW = 4;
  localparam int unsigned EW  = DW + CW;
  localparam logic [CW-1:0]  BUB     = 16'hA5C3;
  localparam logic [CNW-1:0] CNT_MAX = 4'hF;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [DW-1:0]  in_data = '0;
  logic [CW-1:0]  in_ctrl = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [DW-1:0]  out_data;
  logic [CW-1:0]  out_ctrl;
  logic [CNW-1:0] flush_cnt;
  logic [1:0]     dbg_state;

  int n_pass = 0;
  int n_tot  = 0;

  pipe_stage_elastic #(
    .DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .CNT_W(CNW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .flush_cnt (flush_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model: entries held by the stage, oldest first ----------------
  logic [EW-1:0]  exp_q[$];
  logic           m_armed = 1'b0;
  logic [CNW-1:0] m_cnt = '0;
  logic [DW-1:0]  m_last_data = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      exp_q.delete();
      m_armed     = 1'b0;
      m_cnt       = '0;
      m_last_data = '0;
    end else begin
      logic of, inf;
      of  = (exp_q.size() > 0) && out_ready;
      inf = in_valid && m_armed && (exp_q.size() < 2) && !flush;
      if (flush) begin
        if (exp_q.size() > 0 && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
        exp_q.delete();
      end else begin
        if (of) void'(exp_q.pop_front());
        if (inf) exp_q.push_back({in_data, in_ctrl});
      end
      if (exp_q.size() > 0) m_last_data = exp_q[0][EW-1:CW];
      m_armed = 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  initial forever begin
    @(negedge clk);
    begin
      logic          e_valid, e_rdy;
      logic [DW-1:0] e_data;
      logic [CW-1:0] e_ctrl;
      e_valid = (exp_q.size() > 0);
      e_data  = e_valid ? exp_q[0][EW-1:CW] : m_last_data;
      e_ctrl  = e_valid ? exp_q[0][CW-1:0] : BUB;
      e_rdy   = m_armed && (exp_q.size() < 2) && !flush;
      chk("m_out_valid", 64'(out_valid), 64'(e_valid));
      chk("m_out_data",  64'(out_data),  64'(e_data));
      chk("m_out_ctrl",  64'(out_ctrl),  64'(e_ctrl));
      chk("m_in_ready",  64'(in_ready),  64'(e_rdy));
      chk("m_flush_cnt", 64'(flush_cnt), 64'(m_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle_in(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                          input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    flush     = f;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl",  64'(out_ctrl),  64'(BUB));
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);

    // 1: streaming at full rate
    for (int i = 0; i < 8; i++) begin
      cycle_in(1'b1, DW'(i), CW'(16'h100 + i), 1'b1, 1'b0);
      @(negedge clk);
      chk("t1_in_ready", 64'(in_ready), 64'd1);
      if (i == 0) chk("t1_latency", 64'(out_valid), 64'd0);
      else chk("t1_out_data", 64'(out_data), 64'(i - 1));
    end
    cycle_in(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_last_data", 64'(out_data), 64'd7);
    chk("t1_last_ctrl", 64'(out_ctrl), 64'h107);
    cycle_in(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_drained", 64'(out_valid), 64'd0);

    // 2: fill while stalled, then drain
    do_reset();
    cycle_in(1'b1, 32'hAAAA_0001, 16'h00A1, 1'b0, 1'b0);
    cycle_in(1'b1, 32'hBBBB_0002, 16'h00B2, 1'b0, 1'b0);
    cycle_in(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    chk("t2_hold_a",     64'(out_data), 64'hAAAA_0001);
    cycle_in(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_stable_a", 64'(out_ctrl), 64'h00A1);
    cycle_in(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_out_a", 64'(out_data), 64'hAAAA_0001);
    cycle_in(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_out_b",   64'(out_data), 64'hBBBB_0002);
    chk("t2_ready_b", 64'(in_ready), 64'd1);
    cycle_in(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_empty", 64'(out_valid), 64'd0);

    // 3: flush while full with a concurrent input
    do_reset();
    cycle_in(1'b1, 32'h0000_00A0, 16'h0A0A, 1'b0, 1'b0);
    cycle_in(1'b1, 32'h0000_00B0, 16'h0B0B, 1'b0, 1'b0);
    cycle_in(1'b1, 32'h0000_00C0, 16'h0C0C, 1'b0, 1'b1);
    @(negedge clk);
    chk("t3_flush_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle_in(1'b0, '0, '0, 1'b1, 1'b0);
      @(negedge clk);
      chk("t3_no_c_valid", 64'(out_valid), 64'd0);
      chk("t3_bubble",     64'(out_ctrl),  64'(BUB));
    end
    chk("t3_flush_cnt", 64'(flush_cnt), 64'd1);
    chk("t3_keep_data", 64'(out_data),  64'h0000_00A0);

    // 4: flush counting and saturation
    do_reset();
    cycle_in(1'b0, '0, '0, 1'b0, 1'b1);
    cycle_in(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_empty_flush", 64'(flush_cnt), 64'd0);
    for (int k = 0; k < (1 << CNW) + 2; k++) begin
      cycle_in(1'b1, DW'(k), CW'(k), 1'b0, 1'b0);
      cycle_in(1'b0, '0, '0, 1'b0, 1'b1);
    end
    cycle_in(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_saturate", 64'(flush_cnt), 64'd15);

    // 5: random traffic
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      cycle_in($urandom_range(0, 99) < 60, DW'($urandom), CW'($urandom_range(0, 65535)),
               $urandom_range(0, 99) < 60, $urandom_range(0, 63) == 0);
    end
    cycle_in(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    // 6: asynchronous reset while full
    do_reset();
    cycle_in(1'b1, 32'h1234_5678, 16'h1111, 1'b0, 1'b0);
    cycle_in(1'b1, 32'h9ABC_DEF0, 16'h2222, 1'b0, 1'b0);
    cycle_in(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_full", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    chk("t6_async_ctrl",  64'(out_ctrl),  64'(BUB));
    chk("t6_async_data",  64'(out_data),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ready_after", 64'(in_ready),  64'd1);
    chk("t6_still_empty", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
